aes256_inv_key_expansion: RTL and testbench

//  Runs the AES-256 key schedule backwards for the decryption datapath.

---
 rtl/aes256_inv_key_expansion.sv | 144 ++++++++++++++
 tb/tb_aes256_inv_key_expansion.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes256_inv_key_expansion.sv
// AES-256 reverse key schedule: loads {RK13,RK14} and streams RK14 down to RK0,
// rebuilding each earlier round key from a two-key sliding window.

module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    // Row 0 of the forward S-box occupies the most significant bits.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign s_o = SBOX[{~a_i, 3'b000} +: 8];
endmodule

module aes256_inv_key_expansion #(
    parameter int unsigned ROUNDS = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy
);
    if (ROUNDS != 14) begin : g_bad_rounds
        $error("aes256_inv_key_expansion: ROUNDS must be 14");
    end

    typedef enum logic {IDLE, RUN} state_e;

    state_e       state_q;
    logic [255:0] window_q;
    logic [127:0] rk_out_q;
    logic [3:0]   rk_round_q;
    logic         rk_valid_q;
    logic         busy_q;
    logic         key_ready_q;

    logic [127:0] prev_rk_d;
    logic [31:0]  sub_word;
    logic [31:0]  g_word;
    logic [7:0]   rcon;

    // window_q = {w[j..j+3], w[j+4..j+7]}, w[j] in the top bits; g() input is w[j+3].
    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .a_i (window_q[128 + 8*b +: 8]),
            .s_o (sub_word[8*b +: 8])
        );
    end

    always_comb begin
        rcon = '0;
        case (rk_round_q)
            4'd1:    rcon = 8'h01;
            4'd3:    rcon = 8'h02;
            4'd5:    rcon = 8'h04;
            4'd7:    rcon = 8'h08;
            4'd9:    rcon = 8'h10;
            4'd11:   rcon = 8'h20;
            4'd13:   rcon = 8'h40;
            default: rcon = '0;
        endcase
        // SubWord commutes with RotWord, so one set of S-boxes serves both cases.
        if (rk_round_q[0]) begin
            g_word = {sub_word[23:0], sub_word[31:24]} ^ {rcon, 24'h000000};
        end else begin
            g_word = sub_word;
        end
        prev_rk_d = {window_q[127:96] ^ g_word,
                     window_q[127:96] ^ window_q[95:64],
                     window_q[95:64]  ^ window_q[63:32],
                     window_q[63:32]  ^ window_q[31:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            window_q    <= '0;
            rk_out_q    <= '0;
            rk_round_q  <= '0;
            rk_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            key_ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (key_valid) begin
                        window_q    <= key_in;
                        rk_out_q    <= key_in[127:0];
                        rk_round_q  <= 4'(ROUNDS);
                        rk_valid_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        key_ready_q <= 1'b0;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    if (rk_ready) begin
                        if (rk_round_q == 4'(ROUNDS)) begin
                            rk_out_q   <= window_q[255:128];
                            rk_round_q <= rk_round_q - 4'd1;
                        end else if (rk_round_q != 4'd0) begin
                            rk_out_q   <= prev_rk_d;
                            window_q   <= {prev_rk_d, window_q[255:128]};
                            rk_round_q <= rk_round_q - 4'd1;
                        end else begin
                            rk_valid_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            key_ready_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign key_ready = key_ready_q;
    assign rk_out    = rk_out_q;
    assign rk_round  = rk_round_q;
    assign rk_valid  = rk_valid_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_aes256_inv_key_expansion.sv
// Directed bench for aes256_inv_key_expansion: forward-expanded reference keys,
// backpressure, ignored key_valid during RUN, mid-run reset and back-to-back reload.

module tb_aes256_inv_key_expansion;
    logic         clk;
    logic         rst;
    logic [255:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;

    int unsigned errors;
    int unsigned checks;
    logic [127:0] rk_m [0:14];

    localparam logic [255:0] FIPS_KEY =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] FIPS_RK1 = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] FIPS_RK0 = 128'h603deb1015ca71be2b73aef0857d7781;

    aes256_inv_key_expansion #(.ROUNDS(14)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk_out    (rk_out),
        .rk_round  (rk_round),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = '0;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // S-box from its algebraic definition: GF(2^8) inverse followed by the affine map.
    function automatic logic [7:0] sbox_m(input logic [7:0] x);
        logic [7:0] inv;
        inv = '0;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_m(w[31:24]), sbox_m(w[23:16]), sbox_m(w[15:8]), sbox_m(w[7:0])};
    endfunction

    task automatic expand(input logic [255:0] key);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xtime(rc);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int n = 0; n < 15; n++) rk_m[n] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endtask

    task automatic load(input logic [255:0] k);
        int unsigned waited;
        waited = 0;
        while (!key_ready && waited < 40) begin
            step;
            waited++;
        end
        if (waited >= 40) check_eq("key_ready_wait", 128'(key_ready), 128'(1));
        key_in = k;
        key_valid = 1'b1;
        step;
        key_valid = 1'b0;
        check_eq("load_rk_valid", 128'(rk_valid), 128'(1));
        check_eq("load_busy", 128'(busy), 128'(1));
    endtask

    // Walks the sequence from RK14; optional stall, key_valid pulse, early stop.
    task automatic run_seq(input int stall_r, input int pulse_r, input int stop_r);
        for (int r = 14; r >= 0; r--) begin
            check_eq($sformatf("rk_valid_r%0d", r), 128'(rk_valid), 128'(1));
            check_eq($sformatf("rk_round_r%0d", r), 128'(rk_round), 128'(r));
            check_eq($sformatf("rk_out_r%0d", r), rk_out, rk_m[r]);
            if (r == stop_r) return;
            if (r == stall_r) begin
                rk_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    step;
                    check_eq($sformatf("stall_round_c%0d", c), 128'(rk_round), 128'(r));
                    check_eq($sformatf("stall_out_c%0d", c), rk_out, rk_m[r]);
                end
            end
            if (r == pulse_r) begin
                key_in = ~FIPS_KEY;
                key_valid = 1'b1;
                check_eq("run_key_ready", 128'(key_ready), 128'(0));
            end
            rk_ready = 1'b1;
            step;
            key_valid = 1'b0;
        end
        check_eq("end_rk_valid", 128'(rk_valid), 128'(0));
        check_eq("end_busy", 128'(busy), 128'(0));
        check_eq("end_key_ready", 128'(key_ready), 128'(1));
        check_eq("end_rk_round_hold", 128'(rk_round), 128'(0));
        check_eq("end_rk_out_hold", rk_out, rk_m[0]);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        key_in = '0;
        key_valid = 1'b0;
        rk_ready = 1'b0;
        step;
        step;
        check_eq("rst_rk_valid", 128'(rk_valid), 128'(0));
        check_eq("rst_busy", 128'(busy), 128'(0));
        check_eq("rst_rk_out", rk_out, 128'(0));
        check_eq("rst_rk_round", 128'(rk_round), 128'(0));
        rst = 1'b0;
        step;
        check_eq("rst_key_ready", 128'(key_ready), 128'(1));

        // FIPS-197 key, rk_ready held high: 15 back-to-back beats.
        expand(FIPS_KEY);
        load({rk_m[13], rk_m[14]});
        run_seq(-1, -1, -1);
        check_eq("fips_rk0_hand", rk_out, FIPS_RK0);
        check_eq("fips_rk1_model", rk_m[1], FIPS_RK1);

        // All-zero cipher key.
        expand('0);
        load({rk_m[13], rk_m[14]});
        run_seq(-1, 5, -1);
        check_eq("zero_rk0", rk_out, 128'(0));

        // Stall at round 9, key_valid pulse during RUN, then reload on first IDLE cycle.
        expand(FIPS_KEY);
        rk_ready = 1'b0;
        load({rk_m[13], rk_m[14]});
        run_seq(9, 11, -1);
        expand('0);
        key_in = {rk_m[13], rk_m[14]};
        key_valid = 1'b1;
        step;
        key_valid = 1'b0;
        check_eq("b2b_rk_valid", 128'(rk_valid), 128'(1));
        check_eq("b2b_rk_out", rk_out, rk_m[14]);
        run_seq(-1, -1, -1);

        // Reset at round 6, then a full reload.
        expand(FIPS_KEY);
        load({rk_m[13], rk_m[14]});
        run_seq(-1, -1, 6);
        rst = 1'b1;
        step;
        rst = 1'b0;
        check_eq("midrst_rk_valid", 128'(rk_valid), 128'(0));
        check_eq("midrst_busy", 128'(busy), 128'(0));
        check_eq("midrst_rk_out", rk_out, 128'(0));
        check_eq("midrst_key_ready", 128'(key_ready), 128'(1));
        load({rk_m[13], rk_m[14]});
        run_seq(-1, -1, -1);
        check_eq("reload_rk0_hand", rk_out, FIPS_RK0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
